mult_control: RTL and testbench
===============================

MULT_CONTROL -- requirements
Module: mult_control

Interface
REQ-001 The block SHALL have parameter N_BITS, default 8, giving the operand width and the number of add/shift iterations.
REQ-002 Clk  input  1  single clock; the state register updates on posedge.
REQ-003 Reset_n  input  1  asynchronous, active-low reset.
REQ-004 Run  input  1  level start request.
REQ-005 ClearA_LoadB  input  1  in IDLE, request to clear A/X and load B.
REQ-006 M  input  1  current multiplier LSB (B[0]).
REQ-007 Clr_Ld  output  1  load B from switches; clear A and X.
REQ-008 Clr_XA  output  1  clear X and A at run start.
REQ-009 Add  output  1  A <= A + S, with sign extension into X.
REQ-010 Sub  output  1  A <= A - S, with sign extension into X.
REQ-011 Shift  output  1  shift the X:A:B chain right by one.
REQ-012 Busy  output  1  a run is in progress.
REQ-013 Done  output  1  the run is complete and the product is valid.
REQ-014 Iter  output  $clog2(N_BITS)  current iteration index.

Function
REQ-015 The FSM SHALL have exactly five states: IDLE, CLEAR, ADD, SHIFT and HOLD.
REQ-016 In IDLE, Run=1 SHALL move the FSM to CLEAR; otherwise it SHALL stay in IDLE.
REQ-017 In IDLE, Clr_Ld SHALL equal ClearA_LoadB && !Run, so Run wins when both inputs are high.
REQ-018 In CLEAR, Clr_XA SHALL be 1 and Iter SHALL be set to 0; the next state SHALL be ADD.
REQ-019 In ADD, outputs SHALL be Add = M && (Iter != N_BITS-1) and Sub = M && (Iter == N_BITS-1); the next state SHALL be SHIFT.
REQ-020 In SHIFT, Shift SHALL be 1; if Iter == N_BITS-1 the next state SHALL be HOLD, else Iter SHALL increment and the next state SHALL be ADD.
REQ-021 In HOLD, Done SHALL be 1; Run=0 SHALL return the FSM to IDLE, and Run=1 SHALL keep it in HOLD (one run per Run assertion).
REQ-022 Busy SHALL be 1 in CLEAR, ADD and SHIFT, and 0 otherwise.
REQ-023 Strobes SHALL be Moore-decoded from state (plus M/ClearA_LoadB as stated above) and stable from posedge, giving the negedge-clocked datapath registers half a cycle of setup.
REQ-024 In any cycle, at most one of Clr_Ld, Clr_XA, Add, Sub and Shift SHALL be 1.
REQ-025 Latency SHALL be as follows: Run sampled at posedge t0 gives CLEAR in cycle t0+1, ADD/SHIFT pairs in cycles t0+2..t0+2N_BITS+1, and Done=1 from t0+2N_BITS+2.
REQ-026 Iter SHALL never exceed N_BITS-1, and SHALL hold its value in HOLD and IDLE.
REQ-027 ClearA_LoadB SHALL be ignored outside IDLE, and M SHALL be ignored outside ADD.

Reset
REQ-028 Reset_n=0 SHALL immediately force state IDLE and Iter=0, regardless of the current state, including mid-run.
REQ-029 While Reset_n=0, all outputs SHALL be 0, including Clr_Ld.
REQ-030 After reset release, the block SHALL require a fresh Run=1 sample to start.

Structure
REQ-031 Package mult_pkg SHALL hold the state enum typedef and the default N_BITS constant.
REQ-032 The iteration counter SHALL be the sub-module iter_counter, with clear, increment and terminal-count output.
REQ-033 The FSM and output decode SHALL live in mult_control.

Verification
REQ-034 With N_BITS=8, M=1 throughout and a Run pulse, the bench SHALL observe 1 Clr_XA, 7 Add, 1 Sub (at Iter=7) and 8 Shift, with Done=1 at t0+18.
REQ-035 With M=0 throughout and Run, the bench SHALL observe 0 Add, 0 Sub and 8 Shift, with Done timing identical to REQ-034.
REQ-036 With Run held high for 40 cycles, the FSM SHALL stay in HOLD and no second CLEAR SHALL occur; Run low for 1 cycle then high SHALL start a new run.
REQ-037 With ClearA_LoadB=1 alone in IDLE, Clr_Ld SHALL be 1; with Run=1 as well, Clr_Ld SHALL be 0 and CLEAR SHALL follow; with ClearA_LoadB=1 while Busy, Clr_Ld SHALL be 0.
REQ-038 Driving Reset_n low during ADD at Iter=3 SHALL clear Busy, all strobes and Iter to 0 without waiting for a clock edge; after release, the FSM SHALL be in IDLE.
REQ-039 Integrated with 8-bit shift registers, S=0xFD (-3) and B=0x07 SHALL give A:B=0xFFEB (-21) once Done=1.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and defaults for the add/shift multiplier controller.
package mult_pkg;

  localparam int N_BITS_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

endpackage

// File: rtl/mult_control_iter_counter.sv
// Iteration counter for the multiplier: synchronous clear, increment,
// terminal count at N_BITS-1. Saturates at terminal count so the index
// can never run past the last iteration.
module iter_counter #(
  parameter int N_BITS = 8,
  parameter int ITER_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              incr_i,
  output logic [ITER_W-1:0] count_o,
  output logic              tc_o
);

  localparam logic [ITER_W-1:0] LAST = ITER_W'(N_BITS - 1);

  logic [ITER_W-1:0] count_q;
  logic [ITER_W-1:0] count_d;

  // Next count: clear wins, increment only below terminal count.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (incr_i && (count_q != LAST)) begin
      count_d = count_q + ITER_W'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == LAST);

endmodule

// File: rtl/mult_control.sv
// Sequencer for an add/shift signed multiplier. Strobes are decoded from
// the registered state so they settle right after posedge and the
// negedge-clocked datapath gets half a cycle of setup.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for Run; ClearA_LoadB may load B / clear A,X
// ST_CLEAR | run start: clear X and A, reset the iteration index
// ST_ADD   | add (or subtract on last iteration) S when M is set
// ST_SHIFT | shift X:A:B right; advance index or finish
// ST_HOLD  | product valid; wait for Run to drop
module mult_control
  import mult_pkg::*;
#(
  parameter  int N_BITS = N_BITS_DEFAULT,
  localparam int ITER_W = (N_BITS > 1) ? $clog2(N_BITS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  input  logic              clear_a_load_b_i,
  input  logic              m_i,
  output logic              clr_ld_o,
  output logic              clr_xa_o,
  output logic              add_o,
  output logic              sub_o,
  output logic              shift_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ITER_W-1:0] iter_o
);

  state_e state_q;
  state_e state_d;

  logic cnt_clear;
  logic cnt_incr;
  logic cnt_tc;
  logic clr_ld;

  iter_counter #(
    .N_BITS (N_BITS),
    .ITER_W (ITER_W)
  ) u_iter_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (cnt_clear),
    .incr_i  (cnt_incr),
    .count_o (iter_o),
    .tc_o    (cnt_tc)
  );

  // Next-state and Moore strobe decode.
  always_comb begin
    state_d   = state_q;
    clr_ld    = 1'b0;
    clr_xa_o  = 1'b0;
    add_o     = 1'b0;
    sub_o     = 1'b0;
    shift_o   = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    cnt_clear = 1'b0;
    cnt_incr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        clr_ld = clear_a_load_b_i && !run_i;
        if (run_i) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        clr_xa_o  = 1'b1;
        busy_o    = 1'b1;
        cnt_clear = 1'b1;
        state_d   = ST_ADD;
      end
      ST_ADD: begin
        // The multiplier MSB carries negative weight, hence subtract last.
        add_o   = m_i && !cnt_tc;
        sub_o   = m_i && cnt_tc;
        busy_o  = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift_o = 1'b1;
        busy_o  = 1'b1;
        if (cnt_tc) begin
          state_d = ST_HOLD;
        end else begin
          cnt_incr = 1'b1;
          state_d  = ST_ADD;
        end
      end
      ST_HOLD: begin
        done_o = 1'b1;
        if (!run_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Clr_Ld passes the input straight through in IDLE, so it must be
  // masked explicitly while reset is asserted.
  assign clr_ld_o = clr_ld && rst_n;

  // State register, forced to IDLE asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_mult_control.sv
module tb_mult_control;

  localparam int N = 8;

  typedef struct packed {
    logic       clr_ld;
    logic       clr_xa;
    logic       add;
    logic       sub;
    logic       shift;
    logic       busy;
    logic       done;
    logic [2:0] iter;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       load;
  logic       m_drv;
  logic       use_dp;
  logic       m_sig;
  logic       clr_ld, clr_xa, add, sub, shift, busy, done;
  logic [2:0] iter;

  // bench-side datapath
  logic [7:0] a_q, b_q, s_reg, sw;
  logic       x_q;

  int   vectors;
  int   miscompares;
  logic [2:0] iter_model;
  vec_t exp_q[$];

  assign m_sig = use_dp ? b_q[0] : m_drv;

  mult_control #(.N_BITS(N)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .run_i            (run),
    .clear_a_load_b_i (load),
    .m_i              (m_sig),
    .clr_ld_o         (clr_ld),
    .clr_xa_o         (clr_xa),
    .add_o            (add),
    .sub_o            (sub),
    .shift_o          (shift),
    .busy_o           (busy),
    .done_o           (done),
    .iter_o           (iter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clr_ld) begin
      a_q <= 8'h00; x_q <= 1'b0; b_q <= sw;
    end else if (clr_xa) begin
      a_q <= 8'h00; x_q <= 1'b0;
    end else if (add) begin
      {x_q, a_q} <= {a_q[7], a_q} + {s_reg[7], s_reg};
    end else if (sub) begin
      {x_q, a_q} <= {a_q[7], a_q} - {s_reg[7], s_reg};
    end else if (shift) begin
      a_q <= {x_q, a_q[7:1]};
      b_q <= {a_q[0], b_q[7:1]};
    end
  end

  function automatic vec_t observe();
    vec_t v;
    v.clr_ld = clr_ld; v.clr_xa = clr_xa; v.add = add; v.sub = sub;
    v.shift = shift; v.busy = busy; v.done = done; v.iter = iter;
    return v;
  endfunction

  function automatic vec_t idle_vec(input logic [2:0] it);
    vec_t v;
    v = '0;
    v.iter = it;
    return v;
  endfunction

  // Expected per-cycle outputs from cycle t0+1 through the first HOLD cycle.
  task automatic push_run(input logic m_val);
    vec_t v;
    v = '0; v.clr_xa = 1'b1; v.busy = 1'b1; v.iter = iter_model;
    exp_q.push_back(v);
    for (int i = 0; i < N; i++) begin
      v = '0; v.busy = 1'b1; v.iter = 3'(i);
      v.add = m_val && (i != N - 1);
      v.sub = m_val && (i == N - 1);
      exp_q.push_back(v);
      v = '0; v.busy = 1'b1; v.iter = 3'(i); v.shift = 1'b1;
      exp_q.push_back(v);
    end
    v = '0; v.done = 1'b1; v.iter = 3'(N - 1);
    exp_q.push_back(v);
    iter_model = 3'(N - 1);
  endtask

  task automatic test_reset();
    vec_t obs;
    #3;
    obs = observe();
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_asserted: got %h expected %h", obs, 10'h0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = observe();
      vectors++;
      if (obs !== idle_vec(3'd0)) begin
        miscompares++;
        $display("FAIL reset_release_idle[%0d]: got %h expected %h", i, obs, idle_vec(3'd0));
      end
    end
  endtask

  task automatic test_run(input logic m_val);
    vec_t obs, exp;
    int   cyc, done_cyc, n_xa, n_add, n_sub, n_sh;
    cyc = 0; done_cyc = -1; n_xa = 0; n_add = 0; n_sub = 0; n_sh = 0;
    m_drv = m_val;
    run   = 1'b1;
    push_run(m_val);
    @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    while (exp_q.size() > 0) begin
      cyc++;
      exp = exp_q.pop_front();
      obs = observe();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL run_m%0b cycle t0+%0d: got %h expected %h", m_val, cyc, obs, exp);
      end
      n_xa += int'(obs.clr_xa); n_add += int'(obs.add);
      n_sub += int'(obs.sub); n_sh += int'(obs.shift);
      if (obs.done === 1'b1 && done_cyc < 0) done_cyc = cyc;
      @(negedge clk);
    end
    vectors++;
    if (n_xa != 1 || n_add != (m_val ? N - 1 : 0) || n_sub != (m_val ? 1 : 0) || n_sh != N) begin
      miscompares++;
      $display("FAIL run_m%0b counts: got xa=%0d add=%0d sub=%0d shift=%0d expected xa=1 add=%0d sub=%0d shift=%0d",
               m_val, n_xa, n_add, n_sub, n_sh, m_val ? N - 1 : 0, m_val ? 1 : 0, N);
    end
    vectors++;
    if (done_cyc != 2 * N + 2) begin
      miscompares++;
      $display("FAIL run_m%0b done_latency: got t0+%0d expected t0+%0d", m_val, done_cyc, 2 * N + 2);
    end
  endtask

  task automatic test_run_held();
    vec_t obs, exp;
    m_drv = 1'b1;
    run   = 1'b1;
    push_run(1'b1);
    @(posedge clk);
    @(negedge clk);
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      obs = observe();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL held_run: got %h expected %h", obs, exp);
      end
      @(negedge clk);
    end
    exp = '0; exp.done = 1'b1; exp.iter = 3'(N - 1);
    for (int i = 0; i < 22; i++) begin
      obs = observe();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL held_hold[%0d]: got %h expected %h", i, obs, exp);
      end
      @(negedge clk);
    end
    run = 1'b0;
    obs = observe();
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL held_drop_same_cycle: got %h expected %h", obs, exp);
    end
    @(negedge clk);
    obs = observe();
    vectors++;
    if (obs !== idle_vec(iter_model)) begin
      miscompares++;
      $display("FAIL held_back_to_idle: got %h expected %h", obs, idle_vec(iter_model));
    end
    run = 1'b1;
    push_run(1'b1);
    @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      obs = observe();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL held_second_run: got %h expected %h", obs, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clear_load();
    vec_t obs, exp;
    m_drv = 1'b0;
    load  = 1'b1;
    #1;
    exp = idle_vec(iter_model); exp.clr_ld = 1'b1;
    obs = observe();
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL clr_ld_alone: got %h expected %h", obs, exp);
    end
    run = 1'b1;
    #1;
    obs = observe();
    vectors++;
    if (obs !== idle_vec(iter_model)) begin
      miscompares++;
      $display("FAIL clr_ld_run_wins: got %h expected %h", obs, idle_vec(iter_model));
    end
    push_run(1'b0);
    @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      obs = observe();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL clr_ld_while_busy: got %h expected %h", obs, exp);
      end
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic test_datapath();
    logic [7:0]  s_tab [2];
    logic [7:0]  b_tab [2];
    logic [15:0] p_tab [2];
    int          waited;
    s_tab[0] = 8'hFD; b_tab[0] = 8'h07; p_tab[0] = 16'hFFEB;
    s_tab[1] = 8'h05; b_tab[1] = 8'hFA; p_tab[1] = 16'hFFE2;
    use_dp = 1'b1;
    for (int k = 0; k < 2; k++) begin
      s_reg = s_tab[k];
      sw    = b_tab[k];
      load  = 1'b1;
      repeat (2) @(negedge clk);
      load = 1'b0;
      run  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      run = 1'b0;
      waited = 0;
      while (done !== 1'b1 && waited < 40) begin
        @(negedge clk);
        waited++;
      end
      #1;
      vectors++;
      if (done !== 1'b1) begin
        miscompares++;
        $display("FAIL datapath[%0d] done_timeout: got done=%b expected 1", k, done);
      end else if ({a_q, b_q} !== p_tab[k]) begin
        miscompares++;
        $display("FAIL datapath[%0d] product: got %h expected %h", k, {a_q, b_q}, p_tab[k]);
      end
      @(negedge clk);
    end
    iter_model = 3'(N - 1);
    use_dp = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    vec_t obs;
    int   waited;
    m_drv = 1'b1;
    run   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    waited = 0;
    while (!(add === 1'b1 && iter === 3'd3) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (!(add === 1'b1 && iter === 3'd3)) begin
      miscompares++;
      $display("FAIL midrun_reach_add3: got add=%b iter=%0d expected add=1 iter=3", add, iter);
    end
    #1;
    rst_n = 1'b0;
    #1;
    obs = observe();
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL midrun_async_reset: got %h expected %h", obs, 10'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    iter_model = 3'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = observe();
      vectors++;
      if (obs !== idle_vec(3'd0)) begin
        miscompares++;
        $display("FAIL midrun_after_release[%0d]: got %h expected %h", i, obs, idle_vec(3'd0));
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    iter_model  = 3'd0;
    rst_n  = 1'b0;
    run    = 1'b0;
    load   = 1'b1;
    m_drv  = 1'b0;
    use_dp = 1'b0;
    s_reg  = 8'h00;
    sw     = 8'h00;
    test_reset();
    test_run(1'b1);
    test_run(1'b0);
    test_run_held();
    test_clear_load();
    test_datapath();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
